// File: rtl/gift_pkg.sv
// Shared constants and state encoding for the GIFT-128 round sequencer and
// the iterative datapath it controls.
package gift_pkg;

  localparam int GIFT_ROUNDS  = 40;
  localparam int GIFT_ROUND_W = 6;
  localparam int GIFT_BLOCK_W = 128;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } gift_state_t;

endpackage

// File: rtl/gift_round_sequencer_if.sv
// Host strobe / datapath control bundle of the GIFT-128 round sequencer.
// The host drives the write/abort strobes; the sequencer drives everything else.
interface gift_round_sequencer_if #(
  parameter int ROUND_W = gift_pkg::GIFT_ROUND_W
);

  logic               inKeyWr;
  logic               inDataWr;
  logic               inAbort;
  logic               outKeyschLoad;
  logic               outKeyschRewind;
  logic               outKeyschStep;
  logic               outRoundRegLoad;
  logic               outRoundRegStep;
  logic               outDataOutRegWr;
  logic [ROUND_W-1:0] outRoundIdx;
  logic               outBusy;
  logic               outDone;
  logic               outReject;

  modport master (
    output inKeyWr, inDataWr, inAbort,
    input  outKeyschLoad, outKeyschRewind, outKeyschStep,
    input  outRoundRegLoad, outRoundRegStep, outDataOutRegWr,
    input  outRoundIdx, outBusy, outDone, outReject
  );

  modport slave (
    input  inKeyWr, inDataWr, inAbort,
    output outKeyschLoad, outKeyschRewind, outKeyschStep,
    output outRoundRegLoad, outRoundRegStep, outDataOutRegWr,
    output outRoundIdx, outBusy, outDone, outReject
  );

endinterface

// File: rtl/gift_round_sequencer.sv
// Control FSM for the iterative one-round GIFT-128 datapath: loads key and
// plaintext, steps 40 rounds, writes the ciphertext register, reports status.
module gift_round_sequencer
  import gift_pkg::*;
#(
  parameter int NUM_ROUNDS = GIFT_ROUNDS,
  parameter int ROUND_W    = GIFT_ROUND_W
) (
  input logic                   inClk,
  input logic                   inRstN,
  gift_round_sequencer_if.slave bus
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  gift_state_t        state;
  logic [ROUND_W-1:0] count;
  logic               key_valid;
  logic               done;
  logic               reject;

  logic keysch_load;
  logic keysch_rewind;
  logic keysch_step;
  logic round_load;
  logic round_step;
  logic out_wr;

  logic start_ok;
  logic last_round;

  assign start_ok   = bus.inDataWr && (key_valid || bus.inKeyWr);
  assign last_round = (count == LAST_ROUND);

  // Strobes are gated by reset so the datapath sees nothing while it is held.
  always_comb begin
    keysch_load   = 1'b0;
    keysch_rewind = 1'b0;
    keysch_step   = 1'b0;
    round_load    = 1'b0;
    round_step    = 1'b0;
    out_wr        = 1'b0;
    if (inRstN) begin
      unique case (state)
        ST_IDLE: begin
          keysch_load = bus.inKeyWr;
          if (start_ok) begin
            round_load    = 1'b1;
            keysch_rewind = !bus.inKeyWr;
          end
        end
        ST_RUN: begin
          if (!bus.inAbort) begin
            if (last_round) begin
              out_wr = 1'b1;
            end else begin
              round_step  = 1'b1;
              keysch_step = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state     <= ST_IDLE;
      count     <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.inKeyWr) begin
            key_valid <= 1'b1;
          end
          if (start_ok) begin
            state <= ST_RUN;
            count <= '0;
          end else if (bus.inDataWr) begin
            reject <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.inAbort) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (last_round) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign bus.outKeyschLoad   = keysch_load;
  assign bus.outKeyschRewind = keysch_rewind;
  assign bus.outKeyschStep   = keysch_step;
  assign bus.outRoundRegLoad = round_load;
  assign bus.outRoundRegStep = round_step;
  assign bus.outDataOutRegWr = out_wr;
  assign bus.outRoundIdx     = count;
  assign bus.outBusy         = (state == ST_RUN);
  assign bus.outDone         = done;
  assign bus.outReject       = reject;

endmodule

// File: tb/tb_gift_round_sequencer.sv
// Scoreboard bench for gift_round_sequencer: directed host strobes push the
// expected per-cycle output vectors; a negedge monitor pops and compares.
module tb_gift_round_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gift_round_sequencer_if #(.ROUND_W(6)) bus ();

  gift_round_sequencer #(.NUM_ROUNDS(40), .ROUND_W(6)) dut (
    .inClk (clk),
    .inRstN(rst_n),
    .bus   (bus)
  );

  // {load, rewind, kstep, rrload, rrstep, dout_wr, busy, done, reject, idx[5:0]}
  localparam logic [14:0] B_LD = 15'h4000;
  localparam logic [14:0] B_RW = 15'h2000;
  localparam logic [14:0] B_KS = 15'h1000;
  localparam logic [14:0] B_RL = 15'h0800;
  localparam logic [14:0] B_RS = 15'h0400;
  localparam logic [14:0] B_DW = 15'h0200;
  localparam logic [14:0] B_BZ = 15'h0100;
  localparam logic [14:0] B_DN = 15'h0080;
  localparam logic [14:0] B_RJ = 15'h0040;

  logic [14:0] obs;
  assign obs = {bus.outKeyschLoad, bus.outKeyschRewind, bus.outKeyschStep,
                bus.outRoundRegLoad, bus.outRoundRegStep, bus.outDataOutRegWr,
                bus.outBusy, bus.outDone, bus.outReject, bus.outRoundIdx};

  typedef struct {
    int          cyc;
    logic [14:0] vec;
  } exp_t;

  exp_t q[$];

  task automatic push(input int c, input logic [14:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  task automatic push_steps(input int t0, input int n);
    for (int r = 0; r < n; r++) begin
      push(t0 + 1 + r, B_KS | B_RS | B_BZ | 15'(r));
    end
  endtask

  task automatic run_expect(input int t0, input logic [14:0] extra);
    push_steps(t0, 39);
    push(t0 + 40, B_DW | B_BZ | 15'(39));
    push(t0 + 41, B_DN | extra);
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic drive(input logic kw, input logic dw, input logic ab);
    bus.inKeyWr  = kw;
    bus.inDataWr = dw;
    bus.inAbort  = ab;
    @(posedge clk);
    #1;
    bus.inKeyWr  = 1'b0;
    bus.inDataWr = 1'b0;
    bus.inAbort  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Any non-quiet output cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (obs !== 15'h0) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_output cyc %0d: got %h, want no activity", cyc, obs);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc == cyc && e.vec === obs) passed++;
        else $display("FAIL scoreboard cyc %0d: got %h, want %h at cyc %0d", cyc, obs, e.vec, e.cyc);
      end
    end
  end

  initial begin
    int t0;
    bus.inKeyWr  = 1'b0;
    bus.inDataWr = 1'b0;
    bus.inAbort  = 1'b0;
    idle(3);
    check("in_reset", obs, 15'h0);
    rst_n = 1'b1;
    idle(1);
    check("reset_state", obs, 15'h0);

    // Start without a key: refused, one-cycle reject, no strobes.
    t0 = cyc;
    push(t0 + 1, B_RJ);
    drive(1'b0, 1'b1, 1'b0);
    idle(3);

    // Key in cycle k, start in k+2, then a back-to-back start on the done cycle.
    t0 = cyc;
    push(t0, B_LD);
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    t0 = cyc;
    push(t0, B_RL | B_RW);
    run_expect(t0, B_RL | B_RW);
    drive(1'b0, 1'b1, 1'b0);
    idle(40);
    t0 = cyc;
    run_expect(t0, 15'h0);
    drive(1'b0, 1'b1, 1'b0);
    idle(42);

    // Simultaneous key and start: fresh load, no rewind.
    t0 = cyc;
    push(t0, B_LD | B_RL);
    run_expect(t0, 15'h0);
    drive(1'b1, 1'b1, 1'b0);
    idle(42);

    // Host strobes at round 10 are ignored.
    t0 = cyc;
    push(t0, B_RL | B_RW);
    run_expect(t0, 15'h0);
    drive(1'b0, 1'b1, 1'b0);
    idle(10);
    drive(1'b1, 1'b1, 1'b0);
    idle(32);

    // Abort at round 20, then restart on the retained key.
    t0 = cyc;
    push(t0, B_RL | B_RW);
    push_steps(t0, 20);
    push(t0 + 21, B_BZ | 15'(20));
    drive(1'b0, 1'b1, 1'b0);
    idle(20);
    drive(1'b0, 1'b0, 1'b1);
    idle(2);
    t0 = cyc;
    push(t0, B_RL | B_RW);
    run_expect(t0, 15'h0);
    drive(1'b0, 1'b1, 1'b0);
    idle(42);

    // Asynchronous reset at round 25 clears outputs and the key.
    t0 = cyc;
    push(t0, B_RL | B_RW);
    push_steps(t0, 25);
    drive(1'b0, 1'b1, 1'b0);
    idle(25);
    rst_n = 1'b0;
    #1;
    check("async_reset", obs, 15'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    t0 = cyc;
    push(t0 + 1, B_RJ);
    drive(1'b0, 1'b1, 1'b0);
    idle(3);

    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drained: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
